mem_ctrl_param: RTL and testbench
=================================

Name: mem_ctrl_param

Overview:
- Parametrised successor to the team's 32x16 single-port memory.
- Adds configurable width, depth and read latency, plus byte-enable writes, a post-reset clear sequence with a ready flag, and an out-of-range error response.
- Sits behind the same request-style interface (En / Rr_en / Rw_en) and serves as the storage element for the UVM memory bench.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from request acceptance to response; legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- En  in  1  request enable.
- Rr_en  in  1  read request.
- Rw_en  in  1  write request.
- Address  in  ADDR_W  word address.
- Data_in  in  DATA_W  write data.
- Byte_en  in  DATA_W/8  write byte strobes; bit i controls Data_in[8i+7:8i].
- Ready  out  1  block accepts requests.
- Data_out  out  DATA_W  read data.
- Valid_out  out  1  one-cycle pulse marking a read response.
- Err_out  out  1  one-cycle pulse marking an out-of-range access.
- Init_done  out  1  clear sequence complete; stays high until next reset.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-low.
- Reset values (rst=0): Data_out=0, Valid_out=0, Err_out=0, Ready=0, Init_done=0. The response pipeline is flushed and the clear counter is set to 0. Array contents are not reset directly.
- States: INIT, IDLE.
- INIT (entered on rst release):
  - Writes 0 to word[cnt], cnt = 0..DEPTH-1, one word per cycle.
  - Ready=0 throughout.
  - After the write of word DEPTH-1, moves to IDLE. INIT therefore lasts exactly DEPTH cycles.
- IDLE:
  - Ready=1 and Init_done=1, both registered and asserted on the same edge.
  - Stays in IDLE until reset.
- Request acceptance:
  - A request is accepted on a rising edge where Ready=1 and En=1.
  - With En=0, or with Ready=0, the request is ignored entirely: no write and no response.
  - Rr_en=1 is a read; it takes priority, so if Rw_en=1 at the same time no write occurs.
  - Rr_en=0 and Rw_en=1 is a write.
  - En=1 with both Rr_en and Rw_en low is a no-op.
- Write:
  - For each i with Byte_en[i]=1, word[Address] byte i <= Data_in byte i. Other bytes are unchanged.
  - Byte_en=0 writes nothing but is a legal access.
  - A write produces no Valid_out.
- Read:
  - The array is sampled at the accepting edge.
  - Data_out and Valid_out=1 appear RD_LAT cycles after acceptance: with RD_LAT=1, on the next edge, matching the legacy block.
  - Valid_out is high for exactly one cycle per read.
  - Data_out holds its last response value between responses.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
- Back-to-back: one request per cycle is sustained. Responses emerge in order, one per cycle, with no bubbles.
- Out-of-range (Address >= DEPTH):
  - A write has no array effect.
  - A read returns Data_out=0, and a read response carries Valid_out=1 with Err_out=1.
  - Err_out pulses RD_LAT cycles after acceptance, for reads and writes alike. For a write, Valid_out=0.
- Reset mid-operation (rst asserted during INIT or with reads in flight):
  - In-flight responses are discarded, with no Valid_out or Err_out after reset.
  - On rst release, INIT restarts from word 0.
- Pipeline: RD_LAT-deep shift register of {valid, err, data}; stage 1 is loaded at acceptance.

Test Plan:
- Release rst with DEPTH=16 -> Ready=0 for 16 cycles, then Ready=1 and Init_done=1; read of address 5 returns Data_out=0x00000000 with Valid_out=1.
- Write 0xDEADBEEF to address 3 with Byte_en=4'b1111, then write 0x11223344 to address 3 with Byte_en=4'b0101, then read address 3 -> Data_out=0xDE22BE44 with Valid_out=1 one cycle after the read is accepted (RD_LAT=1).
- RD_LAT=3: read addresses 0, 1, 2 back-to-back, pre-written with 0xA, 0xB, 0xC -> Valid_out high for 3 consecutive cycles starting 3 cycles after the first accept; Data_out = 0xA, 0xB, 0xC.
- DEPTH=12, ADDR_W=4: read address 14 -> Valid_out=1, Err_out=1, Data_out=0. Write 0x55 to address 13 -> Err_out=1, Valid_out=0, and a later read of address 13 % 12 = 1 shows it unchanged.
- Rr_en=1 and Rw_en=1 together at address 7, which holds 0x1, with Data_in=0x2 -> response 0x1; a subsequent read still returns 0x1.
- Assert rst while a read is in flight with RD_LAT=4 -> no Valid_out after reset; INIT restarts (Ready low for DEPTH cycles); previously written data reads back as 0.

Source files
------------

// File: rtl/mem_ctrl_param_if.sv
// mem_ctrl_param_if: request/response bus of the parametrised single-port memory.
//   Request  (master -> slave): En, Rr_en, Rw_en, Address, Data_in, Byte_en
//   Response (slave -> master): Ready, Data_out, Valid_out, Err_out, Init_done
interface mem_ctrl_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  En;
  logic                  Rr_en;
  logic                  Rw_en;
  logic [ADDR_W-1:0]     Address;
  logic [DATA_W-1:0]     Data_in;
  logic [DATA_W/8-1:0]   Byte_en;
  logic                  Ready;
  logic [DATA_W-1:0]     Data_out;
  logic                  Valid_out;
  logic                  Err_out;
  logic                  Init_done;

  modport master (
    output En, Rr_en, Rw_en, Address, Data_in, Byte_en,
    input  Ready, Data_out, Valid_out, Err_out, Init_done
  );

  modport slave (
    input  En, Rr_en, Rw_en, Address, Data_in, Byte_en,
    output Ready, Data_out, Valid_out, Err_out, Init_done
  );
endinterface

// File: rtl/mem_ctrl_param.sv
// mem_ctrl_param: parametrised single-port memory with byte-enable writes,
// a post-reset clear sequence, configurable read latency and an
// out-of-range error response.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - slave side of mem_ctrl_param_if (request in, response out)
module mem_ctrl_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_param_if.slave   bus
);

  localparam int                BYTES    = DATA_W / 8;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_ready;
  logic                r_init_done;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  // Response pipeline; stage 0 is loaded at acceptance, the last stage drives the outputs.
  logic                r_pv [RD_LAT];
  logic                r_pe [RD_LAT];
  logic [DATA_W-1:0]   r_pd [RD_LAT];

  logic                w_acc;
  logic                w_rd;
  logic                w_wr;
  logic                w_oor;
  logic [DATA_W-1:0]   w_rd_data;

  // Request decode: read wins over write, out-of-range reads return zero.
  always_comb begin
    w_acc     = r_ready & bus.En;
    w_rd      = w_acc & bus.Rr_en;
    w_wr      = w_acc & ~bus.Rr_en & bus.Rw_en;
    w_oor     = ({1'b0, bus.Address} >= DEPTH_X);
    w_rd_data = {DATA_W{1'b0}};
    if (w_rd && !w_oor) begin
      w_rd_data = r_mem[bus.Address];
    end else begin
      w_rd_data = {DATA_W{1'b0}};
    end
  end

  // Next-state logic: INIT walks the clear counter over every word, then parks in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = r_cnt;
        end else begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = r_cnt + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = r_cnt;
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, clear counter and the Ready/Init_done flags, which rise together on leaving INIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_cnt       <= {ADDR_W{1'b0}};
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_init_done <= (w_state_nxt == S_IDLE);
    end
  end

  // Storage array: cleared word-by-word in INIT, byte-masked writes in IDLE.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= {DATA_W{1'b0}};
    end else if (w_wr && !w_oor) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.Byte_en[i]) begin
          r_mem[bus.Address][8*i +: 8] <= bus.Data_in[8*i +: 8];
        end
      end
    end
  end

  // Response shift register. Data in a stage only moves with a valid read, so the
  // last stage keeps the most recent read data between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        r_pv[k] <= 1'b0;
        r_pe[k] <= 1'b0;
        r_pd[k] <= {DATA_W{1'b0}};
      end
    end else begin
      r_pv[0] <= w_rd;
      r_pe[0] <= (w_rd | w_wr) & w_oor;
      if (w_rd) begin
        r_pd[0] <= w_rd_data;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pe[k] <= r_pe[k-1];
        if (r_pv[k-1]) begin
          r_pd[k] <= r_pd[k-1];
        end
      end
    end
  end

  assign bus.Ready     = r_ready;
  assign bus.Init_done = r_init_done;
  assign bus.Valid_out = r_pv[RD_LAT-1];
  assign bus.Err_out   = r_pe[RD_LAT-1];
  assign bus.Data_out  = r_pd[RD_LAT-1];

endmodule

// File: tb/tb_mem_ctrl_param.sv
// tb_mem_ctrl_param: drives three differently parametrised memories with the same
// stimulus and compares each against a queue-based reference model.
module tb_mem_ctrl_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        rr  = 1'b0;
  logic        rw  = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] din  = 32'd0;
  logic [3:0]  be   = 4'd0;

  always #5 clk = ~clk;

  mem_ctrl_param_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
  mem_ctrl_param_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();
  mem_ctrl_param_if #(.DATA_W(32), .ADDR_W(3)) bus2 ();

  assign bus0.En = en;  assign bus0.Rr_en = rr;  assign bus0.Rw_en = rw;
  assign bus0.Address = addr;  assign bus0.Data_in = din;  assign bus0.Byte_en = be;
  assign bus1.En = en;  assign bus1.Rr_en = rr;  assign bus1.Rw_en = rw;
  assign bus1.Address = addr;  assign bus1.Data_in = din;  assign bus1.Byte_en = be;
  assign bus2.En = en;  assign bus2.Rr_en = rr;  assign bus2.Rw_en = rw;
  assign bus2.Address = addr[2:0];  assign bus2.Data_in = din;  assign bus2.Byte_en = be;

  mem_ctrl_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_ctrl_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_ctrl_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(5),  .RD_LAT(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic        o_rdy [3];
  logic        o_done[3];
  logic        o_v   [3];
  logic        o_e   [3];
  logic [31:0] o_d   [3];

  assign o_rdy[0] = bus0.Ready;  assign o_done[0] = bus0.Init_done;
  assign o_v[0] = bus0.Valid_out;  assign o_e[0] = bus0.Err_out;  assign o_d[0] = bus0.Data_out;
  assign o_rdy[1] = bus1.Ready;  assign o_done[1] = bus1.Init_done;
  assign o_v[1] = bus1.Valid_out;  assign o_e[1] = bus1.Err_out;  assign o_d[1] = bus1.Data_out;
  assign o_rdy[2] = bus2.Ready;  assign o_done[2] = bus2.Init_done;
  assign o_v[2] = bus2.Valid_out;  assign o_e[2] = bus2.Err_out;  assign o_d[2] = bus2.Data_out;

  // Reference model: each accepted request becomes a response due at a given edge.
  typedef struct {
    int          due;
    bit          v;
    bit          e;
    logic [31:0] d;
  } resp_t;

  int          DEP  [3] = '{16, 12, 5};
  int          LAT  [3] = '{1, 3, 4};
  int          AMASK[3] = '{15, 15, 7};
  resp_t       q[3][$];
  logic [31:0] mdl_mem[3][16];
  int          rcnt[3];
  bit          ev[3];
  bit          ee[3];
  logic [31:0] ed[3];
  int          pe;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      rcnt[k] = 0;
      ev[k]   = 1'b0;
      ee[k]   = 1'b0;
      ed[k]   = 32'd0;
      for (int w = 0; w < 16; w++) mdl_mem[k][w] = 32'd0;
    end
  endtask

  task automatic mdl_step();
    resp_t r;
    int    a;
    bit    rdy;
    bit    oor;
    pe++;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        a   = int'(addr) & AMASK[k];
        rdy = (rcnt[k] >= DEP[k]);
        oor = (a >= DEP[k]);
        if (rcnt[k] < DEP[k]) rcnt[k]++;
        if (rdy && en) begin
          r.due = pe + LAT[k] - 1;
          if (rr) begin
            r.v = 1'b1;
            r.e = oor;
            r.d = oor ? 32'd0 : mdl_mem[k][a];
            q[k].push_back(r);
          end else if (rw) begin
            if (!oor) begin
              for (int b = 0; b < 4; b++)
                if (be[b]) mdl_mem[k][a][8*b +: 8] = din[8*b +: 8];
            end else begin
              r.v = 1'b0;
              r.e = 1'b1;
              r.d = 32'd0;
              q[k].push_back(r);
            end
          end
        end
        ev[k] = 1'b0;
        ee[k] = 1'b0;
        if (q[k].size() > 0 && q[k][0].due == pe) begin
          r = q[k].pop_front();
          ev[k] = r.v;
          ee[k] = r.e;
          if (r.v) ed[k] = r.d;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ready%0d@%0d", k, pe), {31'd0, o_rdy[k]},  {31'd0, rcnt[k] >= DEP[k]});
      chk($sformatf("done%0d@%0d", k, pe),  {31'd0, o_done[k]}, {31'd0, rcnt[k] >= DEP[k]});
      chk($sformatf("valid%0d@%0d", k, pe), {31'd0, o_v[k]},    {31'd0, ev[k]});
      chk($sformatf("err%0d@%0d", k, pe),   {31'd0, o_e[k]},    {31'd0, ee[k]});
      chk($sformatf("data%0d@%0d", k, pe),  o_d[k],             ed[k]);
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic step(input bit e, input bit r, input bit w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    en = e; rr = r; rw = w; addr = a; din = d; be = b;
    @(posedge clk);
    mdl_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    mdl_reset();
    #1;
    check_all();
    idle(n);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pe    = 0;
    mdl_reset();
    @(negedge clk);
    check_all();
    idle(2);
    rst = 1'b1;
    idle(16);

    // Fresh read after the clear sequence.
    step(1'b1, 1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
    chk("tp_rd5_valid", {31'd0, o_v[0]}, 32'd1);
    chk("tp_rd5_data", o_d[0], 32'h0000_0000);

    // Byte-enable merge.
    step(1'b1, 1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'b1111);
    step(1'b1, 1'b0, 1'b1, 4'd3, 32'h1122_3344, 4'b0101);
    step(1'b1, 1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
    chk("tp_be_valid", {31'd0, o_v[0]}, 32'd1);
    chk("tp_be_data", o_d[0], 32'hDE22_BE44);

    // Back-to-back reads through the 3-deep pipeline.
    step(1'b1, 1'b0, 1'b1, 4'd0, 32'hA, 4'hF);
    step(1'b1, 1'b0, 1'b1, 4'd1, 32'hB, 4'hF);
    step(1'b1, 1'b0, 1'b1, 4'd2, 32'hC, 4'hF);
    step(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
    chk("tp_lat3_early", {31'd0, o_v[1]}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("tp_lat3_a", o_d[1], 32'hA);
    idle(1);
    chk("tp_lat3_b", o_d[1], 32'hB);
    idle(1);
    chk("tp_lat3_c", o_d[1], 32'hC);
    chk("tp_lat3_v", {31'd0, o_v[1]}, 32'd1);
    idle(1);
    chk("tp_lat3_end", {31'd0, o_v[1]}, 32'd0);

    // Out-of-range read and write on the 12-word instance.
    step(1'b1, 1'b1, 1'b0, 4'd14, 32'd0, 4'd0);
    idle(2);
    chk("tp_oor_rd_v", {31'd0, o_v[1]}, 32'd1);
    chk("tp_oor_rd_e", {31'd0, o_e[1]}, 32'd1);
    chk("tp_oor_rd_d", o_d[1], 32'd0);
    step(1'b1, 1'b0, 1'b1, 4'd13, 32'h55, 4'hF);
    idle(2);
    chk("tp_oor_wr_e", {31'd0, o_e[1]}, 32'd1);
    chk("tp_oor_wr_v", {31'd0, o_v[1]}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
    idle(2);
    chk("tp_oor_alias", o_d[1], 32'hB);

    // Read has priority over a simultaneous write.
    step(1'b1, 1'b0, 1'b1, 4'd7, 32'h1, 4'hF);
    step(1'b1, 1'b1, 1'b1, 4'd7, 32'h2, 4'hF);
    chk("tp_prio_rsp", o_d[0], 32'h1);
    step(1'b1, 1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
    chk("tp_prio_after", o_d[0], 32'h1);

    // Reset with a read in flight in the 4-deep instance, then confirm the clear.
    step(1'b1, 1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    do_reset(2);
    idle(5);
    chk("tp_rst_rdy2", {31'd0, o_rdy[2]}, 32'd1);
    chk("tp_rst_rdy1", {31'd0, o_rdy[1]}, 32'd0);
    idle(11);
    step(1'b1, 1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
    chk("tp_rst_clr", o_d[0], 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 60,
             4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      end
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
